worker_rd_responder: RTL and testbench
======================================

# worker_rd_responder

Return path for worker memory reads: accepts a read request (address, length, response-task template) from a task worker's subtype-0 stage. It issues one AXI read burst per request and tracks each burst in an in-order metadata FIFO. For every returned 32-bit word it emits one task, carrying the word and its index, to the worker's subtype-1 stage. It is the consumer of the worker's `arvalid/araddr/arsize/arlen/resp_task/resp_subtype/resp_mark_last` outputs and the producer of its `in_data/in_word_id/in_cq_slot` inputs.

## Interface
- DEPTH, 8: max outstanding bursts (metadata FIFO entries, power of 2)
- ARID, 0: constant AXI ID driven on m_arid
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- req_valid  in  1  worker read request valid (worker `arvalid`)
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address
- req_size  in  3  AXI size; always 2 (4-byte words)
- req_len  in  8  AXI len; beats = req_len+1
- req_task  in  task_t  template task for every response
- req_subtype  in  subtype_t  subtype for responses
- req_mark_last  in  1  flag final response of burst
- req_cq_slot  in  cq_slice_slot_t  slot carried to responses
- m_arvalid / m_arready  out / in  1  AXI AR handshake
- m_araddr  out  32,  m_arlen out 8,  m_arsize out 3,  m_arid out 6  AXI AR payload
- m_rvalid / m_rready  in / out  1  AXI R handshake
- m_rdata  in  32  read word
- m_rlast  in  1  AXI last beat
- out_valid / out_ready  out / in  1  response task handshake
- out_task  out  task_t  = stored req_task, unmodified
- out_data  out  32  word (worker `in_data`)
- out_word_id  out  8  beat index 0..len (worker `in_word_id`)
- out_subtype  out  subtype_t  stored req_subtype
- out_cq_slot  out  cq_slice_slot_t  stored req_cq_slot
- out_last  out  1  final beat of a burst whose req_mark_last=1
- err_rlast  out  1  sticky: m_rlast disagreed with beat counter

## Operation
- AR stage: one register slot. req_ready = !ar_full & (fifo_count < DEPTH). On accept: load AR register (m_arvalid=1 next cycle), push {task, subtype, cq_slot, mark_last, len} into FIFO in the same cycle. AR register clears on m_arvalid & m_arready; a new request is not accepted in that same cycle (at most one request per 2 cycles on back-to-back).
- FIFO push only when count < DEPTH, even if a pop occurs in the same cycle. Simultaneous push and pop below full: count unchanged.
- R stage: beat counter `beat` (8 bits) for the FIFO head. m_rready = fifo_nonempty & (!out_valid | out_ready). On an R handshake: load output register with head metadata, out_data=m_rdata, out_word_id=beat, out_last = head.mark_last & (beat==head.len).
- End of burst is defined by the counter: when beat==head.len, pop the FIFO and reset beat to 0. Otherwise increment beat.
- m_rlast != (beat==head.len) on a handshake sets err_rlast (cleared only by reset); the counter still governs.
- With FIFO empty, m_rready=0; stray R beats are held, never dropped.
- Data order equals request order (single ARID, in-order AXI).

## Timing
- Reset (async assert, sync-released use): m_arvalid=0, out_valid=0, out_last=0, err_rlast=0, beat=0, fifo_count=0, req_ready=0 while rstn=0. Payload outputs are don't-care but are driven 0.
- Reset mid-burst: all in-flight metadata is discarded; the surrounding system resets memory concurrently.
- Request-to-AR latency: 1 cycle (accept at cycle t → m_arvalid high at t+1).
- R-to-output latency: 1 cycle. Full throughput of 1 beat/cycle while out_ready=1.
- Output register holds all fields stable while out_valid & !out_ready.
- A request pushed at cycle t can match an R beat at t+1 or later (FIFO is write-before-read visible next cycle).

## Test plan
- Single beat: req_len=0, addr=0x1000, mark_last=1, rdata=0xCAFE with rlast=1 → m_araddr=0x1000, m_arlen=0. Exactly one output: word_id=0, data=0xCAFE, out_last=1, FIFO empty afterward.
- Burst of 4 (len=3, mark_last=0) with out_ready toggling 1,0,1,0 → word_ids 0,1,2,3 in order, data unchanged while stalled, out_last never set, m_rready low during stalls.
- Two back-to-back requests (len=1, then len=2, distinct task.object 5 and 9) → 2 outputs with object 5 (ids 0,1), then 3 with object 9 (ids 0,1,2). The second req_ready is low for one cycle after the first accept.
- Fill: DEPTH=8 requests with m_rvalid=0 → req_ready=0 on the 9th. Return one full burst → req_ready reasserts the cycle after the pop.
- rlast error: len=2, rlast asserted on beat 1 → err_rlast=1 from the next cycle, and 3 outputs are still produced. Assert rstn=0 mid-burst → out_valid=0, err_rlast=0, m_arvalid=0 immediately (async).

Source files
------------

// File: rtl/worker_rd_responder.sv
// Worker read return path: one AXI AR burst per request, one response task per R beat, 1-cycle latency each way.
// Back-pressure: req_ready drops while AR is pending or DEPTH bursts are in flight; R beats stall while the output register is held.
package worker_rd_pkg;
  typedef struct packed {
    logic [15:0] object;
    logic [15:0] arg;
  } task_t;

  typedef logic [1:0] subtype_t;
  typedef logic [3:0] cq_slice_slot_t;

  typedef struct packed {
    task_t          tsk;
    subtype_t       subtype;
    cq_slice_slot_t cq_slot;
    logic           mark_last;
    logic [7:0]     len;
  } meta_t;
endpackage

// Generic synchronous FIFO; caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             wdat,
  input  logic                     pop,
  output logic [W-1:0]             rdat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdat = mem[rd_ptr];
endmodule

module worker_rd_responder
  import worker_rd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ARID  = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [31:0]    req_addr,
  input  logic [2:0]     req_size,
  input  logic [7:0]     req_len,
  input  task_t          req_task,
  input  subtype_t       req_subtype,
  input  logic           req_mark_last,
  input  cq_slice_slot_t req_cq_slot,
  output logic           m_arvalid,
  input  logic           m_arready,
  output logic [31:0]    m_araddr,
  output logic [7:0]     m_arlen,
  output logic [2:0]     m_arsize,
  output logic [5:0]     m_arid,
  input  logic           m_rvalid,
  output logic           m_rready,
  input  logic [31:0]    m_rdata,
  input  logic           m_rlast,
  output logic           out_valid,
  input  logic           out_ready,
  output task_t          out_task,
  output logic [31:0]    out_data,
  output logic [7:0]     out_word_id,
  output subtype_t       out_subtype,
  output cq_slice_slot_t out_cq_slot,
  output logic           out_last,
  output logic           err_rlast
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic          r_hs;
  logic          beat_end;
  logic [7:0]    beat;
  meta_t         push_meta;
  meta_t         head;

  assign fifo_nonempty = (fifo_count != '0);
  assign req_ready     = rstn & !m_arvalid & (fifo_count < CW'(DEPTH));
  assign push          = req_valid & req_ready;
  assign push_meta     = '{tsk: req_task, subtype: req_subtype, cq_slot: req_cq_slot,
                           mark_last: req_mark_last, len: req_len};

  // Burst boundaries come from the beat counter, not m_rlast.
  assign beat_end = (beat == head.len);
  assign m_rready = fifo_nonempty & (!out_valid | out_ready);
  assign r_hs     = m_rvalid & m_rready;
  assign pop      = r_hs & beat_end;
  assign m_arid   = 6'(ARID);

  sync_fifo #(.W($bits(meta_t)), .DEPTH(DEPTH)) u_meta_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdat  (push_meta),
    .pop   (pop),
    .rdat  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
    end else if (push) begin
      m_arvalid <= 1'b1;
      m_araddr  <= req_addr;
      m_arlen   <= req_len;
      m_arsize  <= req_size;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat        <= '0;
      err_rlast   <= 1'b0;
      out_valid   <= 1'b0;
      out_task    <= '0;
      out_data    <= '0;
      out_word_id <= '0;
      out_subtype <= '0;
      out_cq_slot <= '0;
      out_last    <= 1'b0;
    end else if (r_hs) begin
      out_valid   <= 1'b1;
      out_task    <= head.tsk;
      out_data    <= m_rdata;
      out_word_id <= beat;
      out_subtype <= head.subtype;
      out_cq_slot <= head.cq_slot;
      out_last    <= head.mark_last & beat_end;
      beat        <= beat_end ? 8'd0 : beat + 8'd1;
      if (m_rlast != beat_end) err_rlast <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_worker_rd_responder.sv
// Directed bench for worker_rd_responder: single beat, stalled burst, back-to-back, fill, rlast error and async reset.
module tb_worker_rd_responder;
  import worker_rd_pkg::*;

  logic           clk = 1'b0;
  logic           rstn;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic [2:0]     req_size;
  logic [7:0]     req_len;
  task_t          req_task;
  subtype_t       req_subtype;
  logic           req_mark_last;
  cq_slice_slot_t req_cq_slot;
  logic           m_arvalid;
  logic           m_arready;
  logic [31:0]    m_araddr;
  logic [7:0]     m_arlen;
  logic [2:0]     m_arsize;
  logic [5:0]     m_arid;
  logic           m_rvalid;
  logic           m_rready;
  logic [31:0]    m_rdata;
  logic           m_rlast;
  logic           out_valid;
  logic           out_ready;
  task_t          out_task;
  logic [31:0]    out_data;
  logic [7:0]     out_word_id;
  subtype_t       out_subtype;
  cq_slice_slot_t out_cq_slot;
  logic           out_last;
  logic           err_rlast;

  int checks = 0;
  int errors = 0;

  worker_rd_responder dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_len(req_len), .req_task(req_task), .req_subtype(req_subtype),
    .req_mark_last(req_mark_last), .req_cq_slot(req_cq_slot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task), .out_data(out_data),
    .out_word_id(out_word_id), .out_subtype(out_subtype), .out_cq_slot(out_cq_slot),
    .out_last(out_last), .err_rlast(err_rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = 0; req_addr = 0; req_size = 3'd2; req_len = 0;
    req_task = '0; req_subtype = 0; req_mark_last = 0; req_cq_slot = 0;
    m_arready = 1; m_rvalid = 0; m_rdata = 0; m_rlast = 0; out_ready = 1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    tick();
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [7:0] len,
                         input logic [15:0] obj, input logic mark);
    req_addr = addr; req_len = len; req_size = 3'd2;
    req_task = '{object: obj, arg: 16'h00AA};
    req_subtype = 2'd1; req_cq_slot = 4'h7; req_mark_last = mark;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [7:0] len,
                          input logic [15:0] obj, input logic mark);
    set_req(addr, len, obj, mark);
    req_valid = 1;
    for (int n = 0; n < 50 && !req_ready; n++) tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_accept_timeout got %b exp 1", req_ready); end
    tick();
    req_valid = 0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic last);
    m_rvalid = 1; m_rdata = data; m_rlast = last;
    for (int n = 0; n < 50 && !m_rready; n++) tick();
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL rready_timeout got %b exp 1", m_rready); end
    tick();
    m_rvalid = 0; m_rlast = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rstn = 0;
    req_valid = 1; m_rvalid = 1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    tick();
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b exp 0", m_arvalid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", out_last); end
    checks++; if (err_rlast !== 1'b0) begin errors++; $display("FAIL rst_err_rlast got %b exp 0", err_rlast); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %b exp 0", m_rready); end
    checks++; if (m_araddr !== 32'h0) begin errors++; $display("FAIL rst_araddr got %h exp 0", m_araddr); end
    do_reset();
  endtask

  task automatic test_single_beat;
    do_reset();
    send_req(32'h1000, 8'd0, 16'd1, 1'b1);
    checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL sb_arvalid got %b exp 1", m_arvalid); end
    checks++; if (m_araddr !== 32'h1000) begin errors++; $display("FAIL sb_araddr got %h exp 1000", m_araddr); end
    checks++; if (m_arlen !== 8'd0) begin errors++; $display("FAIL sb_arlen got %0d exp 0", m_arlen); end
    checks++; if (m_arsize !== 3'd2) begin errors++; $display("FAIL sb_arsize got %0d exp 2", m_arsize); end
    checks++; if (m_arid !== 6'd0) begin errors++; $display("FAIL sb_arid got %0d exp 0", m_arid); end
    r_beat(32'hCAFE, 1'b1);
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL sb_ar_clear got %b exp 0", m_arvalid); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sb_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'hCAFE) begin errors++; $display("FAIL sb_data got %h exp cafe", out_data); end
    checks++; if (out_word_id !== 8'd0) begin errors++; $display("FAIL sb_word_id got %0d exp 0", out_word_id); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL sb_last got %b exp 1", out_last); end
    checks++; if (out_task !== '{object: 16'd1, arg: 16'h00AA}) begin errors++; $display("FAIL sb_task got %h exp 000100aa", out_task); end
    checks++; if (out_subtype !== 2'd1) begin errors++; $display("FAIL sb_subtype got %0d exp 1", out_subtype); end
    checks++; if (out_cq_slot !== 4'h7) begin errors++; $display("FAIL sb_cq_slot got %0d exp 7", out_cq_slot); end
    m_rvalid = 1; m_rdata = 32'hDEAD; m_rlast = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sb_single_output got %b exp 0", out_valid); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL sb_fifo_empty_rready got %b exp 0", m_rready); end
    m_rvalid = 0; m_rlast = 0;
  endtask

  task automatic test_burst_stall;
    logic [31:0] d [4];
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
    do_reset();
    send_req(32'h2000, 8'd3, 16'd2, 1'b0);
    out_ready = 0;
    m_rvalid = 1; m_rdata = d[0]; m_rlast = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin m_rdata = d[i+1]; m_rlast = (i + 1 == 3); end
      else m_rvalid = 0;
      out_ready = 0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bs_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_word_id !== 8'(i)) begin errors++; $display("FAIL bs_word_id[%0d] got %0d exp %0d", i, out_word_id, i); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bs_last[%0d] got %b exp 0", i, out_last); end
      checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL bs_rready_stall[%0d] got %b exp 0", i, m_rready); end
      tick();
      checks++; if (out_data !== d[i]) begin errors++; $display("FAIL bs_data_hold[%0d] got %h exp %h", i, out_data, d[i]); end
      out_ready = 1;
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bs_drained got %b exp 0", out_valid); end
    checks++; if (err_rlast !== 1'b0) begin errors++; $display("FAIL bs_err_rlast got %b exp 0", err_rlast); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_obj;
    logic [7:0]  exp_id;
    do_reset();
    set_req(32'h3000, 8'd1, 16'd5, 1'b0);
    req_valid = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b exp 1", req_ready); end
    tick();
    set_req(32'h3100, 8'd2, 16'd9, 1'b1);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_ready_low got %b exp 0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready_back got %b exp 1", req_ready); end
    tick();
    req_valid = 0;
    checks++; if (m_araddr !== 32'h3100) begin errors++; $display("FAIL b2b_araddr got %h exp 3100", m_araddr); end
    for (int k = 0; k < 5; k++) begin
      m_rvalid = 1; m_rdata = 32'h100 + k; m_rlast = (k == 1 || k == 4);
      #1;
      checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL b2b_rready[%0d] got %b exp 1", k, m_rready); end
      tick();
      exp_obj = (k < 2) ? 16'd5 : 16'd9;
      exp_id  = (k < 2) ? 8'(k) : 8'(k - 2);
      checks++; if (out_task.object !== exp_obj) begin errors++; $display("FAIL b2b_object[%0d] got %0d exp %0d", k, out_task.object, exp_obj); end
      checks++; if (out_word_id !== exp_id) begin errors++; $display("FAIL b2b_word_id[%0d] got %0d exp %0d", k, out_word_id, exp_id); end
      checks++; if (out_data !== 32'h100 + k) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, out_data, 32'h100 + k); end
      checks++; if (out_last !== (k == 4)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", k, out_last, (k == 4)); end
    end
    m_rvalid = 0; m_rlast = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
    checks++; if (err_rlast !== 1'b0) begin errors++; $display("FAIL b2b_err_rlast got %b exp 0", err_rlast); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 8; i++) send_req(32'h4000 + 32'(i) * 4, 8'd0, 16'(i), 1'b1);
    tick();
    set_req(32'h5000, 8'd0, 16'd99, 1'b1);
    req_valid = 1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ninth_ready got %b exp 0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ninth_ready_hold got %b exp 0", req_ready); end
    m_rvalid = 1; m_rdata = 32'h4444; m_rlast = 1;
    #1;
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL fill_rready got %b exp 1", m_rready); end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b exp 1", req_ready); end
    req_valid = 0; m_rvalid = 0; m_rlast = 0;
    checks++; if (out_task.object !== 16'd0) begin errors++; $display("FAIL fill_head_object got %0d exp 0", out_task.object); end
    checks++; if (out_data !== 32'h4444) begin errors++; $display("FAIL fill_data got %h exp 4444", out_data); end
  endtask

  task automatic test_rlast_err_and_reset;
    int outs = 0;
    do_reset();
    send_req(32'h6000, 8'd2, 16'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      r_beat(32'h600 + k, (k == 1));
      if (out_valid === 1'b1) outs++;
      if (k == 0) begin
        checks++; if (err_rlast !== 1'b0) begin errors++; $display("FAIL rl_err_early got %b exp 0", err_rlast); end
      end else if (k == 1) begin
        checks++; if (err_rlast !== 1'b1) begin errors++; $display("FAIL rl_err_set got %b exp 1", err_rlast); end
      end
    end
    checks++; if (out_word_id !== 8'd2) begin errors++; $display("FAIL rl_last_id got %0d exp 2", out_word_id); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rl_out_last got %b exp 1", out_last); end
    checks++; if (outs !== 3) begin errors++; $display("FAIL rl_output_count got %0d exp 3", outs); end
    tick();
    checks++; if (err_rlast !== 1'b1) begin errors++; $display("FAIL rl_err_sticky got %b exp 1", err_rlast); end
    m_arready = 0; out_ready = 0;
    send_req(32'h7000, 8'd3, 16'd4, 1'b0);
    r_beat(32'h700, 1'b0);
    checks++; if (out_valid !== 1'b1 || m_arvalid !== 1'b1) begin errors++; $display("FAIL rl_pre_reset got %b%b exp 11", out_valid, m_arvalid); end
    #2 rstn = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b exp 0", out_valid); end
    checks++; if (err_rlast !== 1'b0) begin errors++; $display("FAIL async_err_rlast got %b exp 0", err_rlast); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL async_arvalid got %b exp 0", m_arvalid); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL async_rready got %b exp 0", m_rready); end
    do_reset();
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL post_reset_fifo_empty got %b exp 0", m_rready); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst_stall();
    test_back_to_back();
    test_fill();
    test_rlast_err_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
